// File: rtl/skid_register.sv
// skid_register: two-entry elastic buffer between a valid/ready producer and consumer.
// The main word drives out_data. The skid word catches the word that was accepted
// on the same edge the consumer stalled. in_ready, out_valid, out_data and occupancy
// are all taken straight from flops, so no input reaches an output combinationally.
//
// state | meaning
// EMPTY | no word held; out_valid low
// BUSY  | one word held in main
// FULL  | main and skid both hold words; in_ready low

module skid_register #(
    parameter int                     WORD_WIDTH  = 32,
    parameter logic [WORD_WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic [1:0]            occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] main_q, main_d;
    logic [WORD_WIDTH-1:0] skid_q, skid_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [1:0]            occupancy_q, occupancy_d;

    logic in_fire;
    logic out_fire;

    // Handshakes are qualified by the registered ready/valid, never by raw inputs.
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Next state, storage moves, and the output flags that belong to the next state.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
        case (state_d)
            BUSY:    occupancy_d = 2'd1;
            FULL:    occupancy_d = 2'd2;
            default: occupancy_d = 2'd0;
        endcase
    end

    // State and output registers; reset holds in_ready low until the first released edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= EMPTY;
            main_q      <= RESET_VALUE;
            skid_q      <= RESET_VALUE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            occupancy_q <= occupancy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = occupancy_q;

endmodule

// File: tb/tb_skid_register.sv
// Bench for skid_register: directed vector table followed by a random run,
// with a queue model of the held words checked after every clock edge.

module tb_skid_register;

    localparam logic [31:0] RV = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    skid_register #(.WORD_WIDTH(32), .RESET_VALUE(RV)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic        flush;
        logic        iv;
        logic [31:0] din;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    bit          rst_edge = 1'b0;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic f, input logic iv, input logic [31:0] d,
                       input logic o, input logic eir, input logic eov,
                       input logic [31:0] eod, input logic [1:0] eocc);
        vec_t v;
        v.rstn = r; v.flush = f; v.iv = iv; v.din = d; v.ordy = o;
        v.e_ir = eir; v.e_ov = eov; v.e_od = eod; v.e_occ = eocc;
        vecs.push_back(v);
    endtask

    // One clock: note handshakes from stable pre-edge values, then update and check the model.
    task automatic step();
        bit          in_f;
        bit          out_f;
        bit          stall;
        logic [31:0] pre_od;
        logic [31:0] pre_in;
        logic [31:0] exp_word;
        in_f   = ((in_valid & in_ready) === 1'b1);
        out_f  = ((out_valid & out_ready) === 1'b1);
        stall  = (out_valid === 1'b1) && (out_ready === 1'b0);
        pre_od = out_data;
        pre_in = in_data;
        @(posedge clk);
        #1;
        if (!rstn) begin
            sb.delete();
            rst_edge = 1'b1;
        end else if (flush) begin
            sb.delete();
            rst_edge = 1'b0;
        end else begin
            rst_edge = 1'b0;
            if (stall) chk("stall_stable", out_data, pre_od);
            if (out_f) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_unexpected_word: got %h expected no output", pre_od);
                end else begin
                    exp_word = sb.pop_front();
                    chk("sb_order", pre_od, exp_word);
                end
            end
            if (in_f) sb.push_back(pre_in);
        end
        chk("model_occ", {30'd0, occupancy}, 32'(sb.size()));
        chk("model_out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
        chk("model_in_ready", {31'd0, in_ready}, {31'd0, !rst_edge && sb.size() < 2});
        if (rst_edge) chk("model_reset_data", out_data, RV);
        else if (sb.size() > 0) chk("model_out_data", out_data, sb[0]);
        n_cmp++;
        if (occupancy === 2'd3) begin
            n_fail++;
            $display("FAIL occ_illegal: got %0d expected 0..2", occupancy);
        end
    endtask

    initial begin
        // reset for three cycles, then release; the word offered on release is refused
        add(0,0,0,32'h0,  0, 0,0,RV,0);
        add(0,0,0,32'h0,  0, 0,0,RV,0);
        add(0,0,1,32'h55, 1, 0,0,RV,0);
        add(1,0,1,32'h77, 0, 1,0,RV,0);
        // streaming 1..8 with out_ready high
        for (int k = 1; k <= 8; k++) add(1,0,1,32'(k), 1, 1,1,32'(k),1);
        add(1,0,0,32'h0,  1, 1,0,32'h8,0);
        // stall: A loaded, B into skid, C refused, then drain A, B, C
        add(1,0,1,32'hA,  0, 1,1,32'hA,1);
        add(1,0,1,32'hB,  0, 0,1,32'hA,2);
        add(1,0,1,32'hC,  0, 0,1,32'hA,2);
        add(1,0,1,32'hC,  0, 0,1,32'hA,2);
        add(1,0,1,32'hC,  1, 1,1,32'hB,1);
        add(1,0,1,32'hC,  1, 1,1,32'hC,1);
        add(1,0,0,32'h0,  1, 1,0,32'hC,0);
        // flush while FULL, D offered on the flush edge is dropped
        add(1,0,1,32'hE1, 0, 1,1,32'hE1,1);
        add(1,0,1,32'hF1, 0, 0,1,32'hE1,2);
        add(1,1,1,32'hD0, 1, 1,0,32'hE1,0);
        add(1,0,0,32'h0,  1, 1,0,32'hE1,0);
        // BUSY with in_fire and out_fire together, then reset while FULL
        add(1,0,1,32'h11, 0, 1,1,32'h11,1);
        add(1,0,1,32'h22, 1, 1,1,32'h22,1);
        add(1,0,1,32'h33, 0, 0,1,32'h22,2);
        add(0,0,1,32'h44, 1, 0,0,RV,0);
        add(1,0,0,32'h0,  1, 1,0,RV,0);
        add(1,0,0,32'h0,  1, 1,0,RV,0);

        #1;
        foreach (vecs[i]) begin
            rstn      = vecs[i].rstn;
            flush     = vecs[i].flush;
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].din;
            out_ready = vecs[i].ordy;
            step();
            chk($sformatf("vec%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].e_ir});
            chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
            chk($sformatf("vec%0d_out_data", i),  out_data,           vecs[i].e_od);
            chk($sformatf("vec%0d_occupancy", i), {30'd0, occupancy}, {30'd0, vecs[i].e_occ});
        end

        for (int c = 0; c < 10000; c++) begin
            rstn      = 1'b1;
            flush     = ($urandom_range(0, 31) == 0);
            in_valid  = $urandom_range(0, 1) != 0;
            in_data   = $urandom;
            out_ready = $urandom_range(0, 1) != 0;
            step();
        end

        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/skid_register.md
SKID_REGISTER -- requirements
Module: skid_register

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32: payload width in bits, legal range 1..1024.
REQ-002 SHALL have parameter RESET_VALUE, default 0, width WORD_WIDTH: value driven on out_data during and after reset.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous discard of all held words.
REQ-006 SHALL have port in_valid  input  1  upstream word present.
REQ-007 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-008 SHALL have port in_data  input  WORD_WIDTH  upstream payload.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-010 SHALL have port out_ready  input  1  downstream accepts a word this cycle.
REQ-011 SHALL have port out_data  output  WORD_WIDTH  downstream payload.
REQ-012 SHALL have port occupancy  output  2  number of held words, 0..2.

Function
REQ-013 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready, both sampled at the rising edge.
REQ-014 SHALL hold two storage words, main (drives out_data) and skid, and SHALL use a state machine with states EMPTY (occupancy 0), BUSY (1) and FULL (2).
REQ-015 SHALL drive in_ready, out_valid, out_data and occupancy directly from flops, with no combinational path from any input to any output.
REQ-016 SHALL drive in_ready=1 in EMPTY and BUSY, in_ready=0 in FULL, and in_ready=0 on the cycle following any reset cycle.
REQ-017 SHALL drive out_valid=1 in BUSY and FULL, and out_valid=0 in EMPTY.
REQ-018 EMPTY on in_fire SHALL load main<=in_data and go to BUSY; otherwise it SHALL stay EMPTY.
REQ-019 BUSY on in_fire and out_fire SHALL load main<=in_data and stay BUSY.
REQ-020 BUSY on in_fire without out_fire SHALL load skid<=in_data and go to FULL.
REQ-021 BUSY on out_fire without in_fire SHALL go to EMPTY, and main SHALL remain unchanged.
REQ-022 FULL on out_fire SHALL load main<=skid and go to BUSY; otherwise it SHALL stay FULL.
REQ-023 SHALL have latency of 1 cycle: a word accepted at edge N appears on out_data with out_valid=1 from edge N onward, first visible in cycle N+1.
REQ-024 SHALL sustain throughput of 1 word/cycle when out_ready is held at 1.
REQ-025 SHALL preserve word order, with no loss and no duplication.
REQ-026 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-027 SHALL ignore in_data whenever in_fire=0.
REQ-028 SHALL ignore out_ready whenever out_valid=0.
REQ-029 flush=1 at an edge SHALL force EMPTY, SHALL discard main and skid contents (data registers need not be cleared), SHALL set in_ready=1, and SHALL take priority over in_fire and out_fire in the same cycle; the word offered at that edge is not accepted.
REQ-030 occupancy SHALL equal 0, 1 or 2 matching EMPTY, BUSY or FULL; value 3 is illegal and SHALL never be driven.

Reset
REQ-031 While rstn=0 at an edge, the block SHALL go to EMPTY, set main<=RESET_VALUE and skid<=RESET_VALUE, and drive out_valid=0, in_ready=0, occupancy=0 and out_data=RESET_VALUE.
REQ-032 Reset SHALL take priority over flush and over all handshakes.
REQ-033 On the first edge with rstn=1, in_ready SHALL rise to 1; no word SHALL be accepted before in_ready=1 is visible.
REQ-034 Reset asserted mid-transfer SHALL discard held words, which SHALL never appear at the output after reset.

Verification
REQ-035 The bench SHALL cover reset: rstn=0 for 3 cycles with RESET_VALUE=32'hDEAD_BEEF -> out_data=DEADBEEF, out_valid=0, in_ready=0, then in_ready=1 one cycle after release.
REQ-036 The bench SHALL cover streaming: in_valid=1 for words 1..8 with out_ready=1 -> out_data 1..8 on consecutive cycles, each 1 cycle after acceptance, occupancy staying at 1.
REQ-037 The bench SHALL cover stall: load A, out_ready=0, offer B then C -> B accepted, occupancy=2, in_ready=0, C held off, out_data=A stable; then out_ready=1 -> A, B, C emitted in order.
REQ-038 The bench SHALL cover flush: in FULL, assert flush with in_valid=1 carrying D -> next cycle occupancy=0, out_valid=0, in_ready=1, and D is never output.
REQ-039 The bench SHALL cover simultaneous events: in BUSY, in_fire and out_fire on the same edge -> stays BUSY with the new word on out_data; in FULL with rstn=0 and out_ready=1 -> EMPTY, no word emitted.
REQ-040 The bench SHALL run 10k cycles of random in_valid/out_ready/flush checked against a queue scoreboard, asserting order, no loss, out_data stability under stall, and occupancy never equal to 3.
